// File: rtl/fib_trace_checker.sv
// Registered monitor for the four-counter selector-driven accumulator stage.
// Optional: define FIB_CHK_FIRST_ZERO_EN to require a zero origin after IDLE (code 5).
module fib_trace_checker #(
  parameter int W     = 11,
  parameter int LIMIT = 300
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         sel,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] i,
  input  logic [W-1:0] j,
  output logic [1:0]   state,
  output logic         err,
  output logic [2:0]   err_code,
  output logic [W-1:0] err_step,
  output logic [W-1:0] step_cnt,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  state_t       st, st_nxt;
  logic [W-1:0] px, py, pi, pj;
  logic         psel, pvalid;

  logic         in_adv, adv_ok, hold_ok, first_bad, step_ok;
  logic [2:0]   code;

`ifdef FIB_CHK_FIRST_ZERO_EN
  assign first_bad = |{x, y, i, j};
`else
  assign first_bad = 1'b0;
`endif

  // All sums are W bits wide, so expectations wrap modulo 2^W.
  always_comb begin
    in_adv  = (pj < LIM);
    adv_ok  = (x == px + ONE) && (y == py + ONE) && (i == pi + px + ONE) &&
              (j == pj + py + (psel ? ONE : TWO));
    hold_ok = (x == px) && (y == py) && (i == pi) && (j == pj);
    step_ok = pvalid && in_adv && adv_ok;

    code = 3'd0;
    if (x != y)                            code = 3'd1;
    else if (j < i)                        code = 3'd2;
    else if (!pvalid && first_bad)         code = 3'd5;
    else if (pvalid && in_adv && !adv_ok)  code = 3'd3;
    else if (pvalid && !in_adv && !hold_ok) code = 3'd4;
  end

  always_comb begin
    st_nxt = st;
    if (!in_valid) begin
      if (st != FAIL) st_nxt = IDLE;
    end else if (code != 3'd0) begin
      st_nxt = FAIL;
    end else begin
      case (st)
        IDLE:    st_nxt = RUN;
        RUN:     if (pvalid && !in_adv) st_nxt = DONE;
        DONE:    if (pvalid && in_adv)  st_nxt = RUN;
        default: st_nxt = st;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 3'd0;
      err_step <= '0;
      step_cnt <= '0;
      px       <= '0;
      py       <= '0;
      pi       <= '0;
      pj       <= '0;
      psel     <= 1'b0;
      pvalid   <= 1'b0;
    end else begin
      st   <= st_nxt;
      done <= (st_nxt == DONE);
      if (!in_valid) begin
        pvalid <= 1'b0;
      end else begin
        px     <= x;
        py     <= y;
        pi     <= i;
        pj     <= j;
        psel   <= sel;
        pvalid <= 1'b1;
        if (step_ok && (step_cnt != '1)) step_cnt <= step_cnt + ONE;
        // First error wins; err_step records the count before this sample.
        if ((code != 3'd0) && !err) begin
          err      <= 1'b1;
          err_code <= code;
          err_step <= step_cnt;
        end
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_fib_trace_checker.sv
// Directed plus randomized bench for fib_trace_checker with a behavioural reference model.
module tb_fib_trace_checker;

  localparam int W     = 11;
  localparam int LIMIT = 300;
  localparam int MASK  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         sel;
  logic [W-1:0] x, y, i, j;
  logic [1:0]   state;
  logic         err;
  logic [2:0]   err_code;
  logic [W-1:0] err_step;
  logic [W-1:0] step_cnt;
  logic         done;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_state, m_err, m_code, m_estep, m_cnt;
  int mpx, mpy, mpi, mpj, mpsel;
  bit mpvalid;

  fib_trace_checker #(.W(W), .LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel),
    .x(x), .y(y), .i(i), .j(j),
    .state(state), .err(err), .err_code(err_code), .err_step(err_step),
    .step_cnt(step_cnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_err = 0; m_code = 0; m_estep = 0; m_cnt = 0;
    mpx = 0; mpy = 0; mpi = 0; mpj = 0; mpsel = 0; mpvalid = 0;
  endtask

  task automatic model_step(input bit v, input int s, input int sx, input int sy,
                            input int si, input int sj);
    int  code;
    int  old_cnt;
    bit  adv_match, hold_match, advancing, nonzero;
    if (!v) begin
      mpvalid = 0;
      if (m_state != 3) m_state = 0;
      return;
    end
    advancing  = (mpj < LIMIT);
    adv_match  = (sx == ((mpx + 1) & MASK)) && (sy == ((mpy + 1) & MASK)) &&
                 (si == ((mpi + mpx + 1) & MASK)) &&
                 (sj == ((mpj + mpy + (mpsel ? 1 : 2)) & MASK));
    hold_match = (sx == mpx) && (sy == mpy) && (si == mpi) && (sj == mpj);
    nonzero    = (sx != 0) || (sy != 0) || (si != 0) || (sj != 0);
    code = 0;
    if (sx != sy) code = 1;
    else if (sj < si) code = 2;
`ifdef FIB_CHK_FIRST_ZERO_EN
    else if (!mpvalid && nonzero) code = 5;
`endif
    else if (mpvalid && advancing && !adv_match) code = 3;
    else if (mpvalid && !advancing && !hold_match) code = 4;
    old_cnt = m_cnt;
    if (mpvalid && advancing && adv_match && m_cnt < MASK) m_cnt++;
    if (code != 0) begin
      if (m_err == 0) begin
        m_err = 1; m_code = code; m_estep = old_cnt;
      end
      m_state = 3;
    end else if (m_state == 0) m_state = 1;
    else if (m_state == 1 && mpvalid && !advancing) m_state = 2;
    else if (m_state == 2 && mpvalid && advancing) m_state = 1;
    mpx = sx; mpy = sy; mpi = si; mpj = sj; mpsel = s; mpvalid = 1;
    if (nonzero) ; // nonzero only matters when the first-zero rule is built in
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_state));
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("err_step", 32'(err_step), 32'(m_estep));
    chk("step_cnt", 32'(step_cnt), 32'(m_cnt));
    chk("done", 32'(done), 32'(m_state == 2));
  endtask

  task automatic drive(input bit v, input int s, input int sx, input int sy,
                       input int si, input int sj);
    in_valid = v; sel = s[0];
    x = W'(sx); y = W'(sy); i = W'(si); j = W'(sj);
    @(posedge clk);
    #1;
    model_step(v, s, sx, sy, si, sj);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; sel = 1'b0;
    x = '0; y = '0; i = '0; j = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  int cx, cy, ci, cj, s, r, nx, ny, ni, nj, f;

  initial begin
    do_reset();
    check_all();
    chk("rst_state", 32'(state), 0);

    // sel=1 trace
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 1, 1);
    drive(1, 1, 2, 2, 3, 3);
    drive(1, 1, 3, 3, 6, 6);
    chk("t1_state", 32'(state), 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_cnt", 32'(step_cnt), 3);

    // sel=0 trace, then the same with a bad last j
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 1, 2);
    drive(1, 0, 2, 2, 3, 5);
    chk("t2_err", 32'(err), 0);
    chk("t2_cnt", 32'(step_cnt), 2);
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 1, 2);
    drive(1, 0, 2, 2, 3, 4);
    chk("t2b_err", 32'(err), 1);
    chk("t2b_code", 32'(err_code), 3);
    chk("t2b_step", 32'(err_step), 1);
    chk("t2b_state", 32'(state), 3);

    // j < i on first sample, later x != y must not overwrite
    do_reset();
    drive(1, 1, 3, 3, 6, 5);
    chk("t3_code", 32'(err_code), 2);
    chk("t3_step", 32'(err_step), 0);
    drive(1, 1, 4, 5, 7, 9);
    chk("t3b_code", 32'(err_code), 2);

    // hold region: DONE, then violate hold keeping x==y
    do_reset();
    drive(1, 1, 5, 5, 100, 300);
    drive(1, 1, 5, 5, 100, 300);
    chk("t4_state", 32'(state), 2);
    chk("t4_done", 32'(done), 1);
    drive(1, 1, 6, 6, 100, 300);
    chk("t4b_code", 32'(err_code), 4);
    chk("t4b_done", 32'(done), 0);

    // valid gap mid-run
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 1, 1);
    drive(1, 1, 2, 2, 3, 3);
    drive(0, 0, 7, 9, 1, 0);
    chk("t5_idle", 32'(state), 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 10, 10, 20, 40);
    chk("t5_state", 32'(state), 1);
    chk("t5_err", 32'(err), 0);
    chk("t5_cnt", 32'(step_cnt), 2);
    drive(1, 1, 11, 11, 31, 51);
    chk("t5b_cnt", 32'(step_cnt), 3);

    // non-zero origin
    do_reset();
    drive(1, 1, 1, 1, 1, 1);
`ifdef FIB_CHK_FIRST_ZERO_EN
    chk("t6_code", 32'(err_code), 5);
`else
    chk("t6_err", 32'(err), 0);
    chk("t6_state", 32'(state), 1);
`endif

    // randomized episodes: ideal upstream trace with occasional faults and gaps
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      cx = 0; cy = 0; ci = 0; cj = 0;
      for (int n = 0; n < 80; n++) begin
        r = $urandom_range(0, 99);
        if (r < 3) begin
          repeat ($urandom_range(1, 2))
            drive(0, 0, $urandom_range(0, MASK), $urandom_range(0, MASK),
                  $urandom_range(0, MASK), $urandom_range(0, MASK));
          cx = $urandom_range(0, 20); cy = cx;
          ci = $urandom_range(0, 200); cj = ci + $urandom_range(0, 150);
        end else begin
          s = $urandom_range(0, 1);
          if (r < 6) begin
            f = $urandom_range(0, 3);
            drive(1, s, (cx + (f == 0)) & MASK, (cy + (f == 1)) & MASK,
                  (ci + (f == 2)) & MASK, (cj + (f == 3)) & MASK);
          end else begin
            drive(1, s, cx, cy, ci, cj);
          end
          if (cj < LIMIT) begin
            nx = (cx + 1) & MASK; ny = (cy + 1) & MASK;
            ni = (ci + cx + 1) & MASK; nj = (cj + cy + (s ? 1 : 2)) & MASK;
            cx = nx; cy = ny; ci = ni; cj = nj;
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
